// File: rtl/pe_pkg.sv
// Shared constants for the pixel engine: pixel width, FSM state encoding,
// and the 9-bit absolute-difference helper used by the background test.
package pe_pkg;

  localparam int PIXEL_W = 8;

  typedef enum logic [2:0] {
    ST_I   = 3'd0,
    ST_BGI = 3'd1,
    ST_BG  = 3'd2,
    ST_BGD = 3'd3,
    ST_SI  = 3'd4,
    ST_S   = 3'd5,
    ST_SD  = 3'd6
  } state_t;

  // Widen to 9 bits first so the subtraction can never wrap.
  function automatic logic [PIXEL_W:0] abs_diff(input logic [PIXEL_W-1:0] a,
                                                 input logic [PIXEL_W-1:0] b);
    logic [PIXEL_W:0] ax;
    logic [PIXEL_W:0] bx;
    ax = {1'b0, a};
    bx = {1'b0, b};
    return (ax >= bx) ? (ax - bx) : (bx - ax);
  endfunction

endpackage

// File: rtl/bg_pixel_compare.sv
// Combinational background test for one pixel: every channel must lie within
// threshold of the expected colour (inclusive) for the pixel to match.
module bg_pixel_compare
  import pe_pkg::*;
(
  input  logic [PIXEL_W-1:0] r,
  input  logic [PIXEL_W-1:0] g,
  input  logic [PIXEL_W-1:0] b,
  input  logic [PIXEL_W-1:0] exp_r,
  input  logic [PIXEL_W-1:0] exp_g,
  input  logic [PIXEL_W-1:0] exp_b,
  input  logic [PIXEL_W-1:0] threshold,
  output logic               match
);

  logic [PIXEL_W:0] thr_wide;

  assign thr_wide = {1'b0, threshold};
  assign match    = (abs_diff(r, exp_r) <= thr_wide) &&
                    (abs_diff(g, exp_g) <= thr_wide) &&
                    (abs_diff(b, exp_b) <= thr_wide);

endmodule

// File: rtl/pe.sv
// Pixel engine: per-channel lane summation or background replacement over
// num_pixels packed 8-bit lanes, one lane per clock, with a done/ack handshake.
module pe
  import pe_pkg::*;
#(
  parameter int num_pixels = 1
) (
  input  logic                          Clk,
  input  logic                          Ack,
  input  logic                          Reset,
  input  logic [PIXEL_W-1:0]            red_exp,
  input  logic [PIXEL_W-1:0]            green_exp,
  input  logic [PIXEL_W-1:0]            blue_exp,
  input  logic [PIXEL_W-1:0]            threshold,
  input  logic [PIXEL_W-1:0]            desired_bg_r,
  input  logic [PIXEL_W-1:0]            desired_bg_g,
  input  logic [PIXEL_W-1:0]            desired_bg_b,
  input  logic                          Start_Sum,
  input  logic                          Start_BgRemoval,
  input  logic [PIXEL_W*num_pixels-1:0] red_in,
  input  logic [PIXEL_W*num_pixels-1:0] green_in,
  input  logic [PIXEL_W*num_pixels-1:0] blue_in,
  output logic [PIXEL_W*num_pixels-1:0] red_out,
  output logic [PIXEL_W*num_pixels-1:0] green_out,
  output logic [PIXEL_W*num_pixels-1:0] blue_out,
  output logic                          Qi,
  output logic                          Qbgi,
  output logic                          Qbg,
  output logic                          Qbgd,
  output logic                          Qsi,
  output logic                          Qs,
  output logic                          Qsd,
  output logic [PIXEL_W*num_pixels-1:0] red_sum,
  output logic [PIXEL_W*num_pixels-1:0] green_sum,
  output logic [PIXEL_W*num_pixels-1:0] blue_sum
);

  localparam int BUS_W = PIXEL_W * num_pixels;
  localparam int IDX_W = (num_pixels > 1) ? $clog2(num_pixels) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(num_pixels - 1);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg;
  logic [BUS_W-1:0]   red_reg, green_reg, blue_reg;
  logic [PIXEL_W-1:0] exp_r_reg, exp_g_reg, exp_b_reg, thr_reg;
  logic [PIXEL_W-1:0] des_r_reg, des_g_reg, des_b_reg;
  logic [BUS_W-1:0]   sum_r_reg, sum_g_reg, sum_b_reg;

  logic [PIXEL_W-1:0] red_lane   [num_pixels];
  logic [PIXEL_W-1:0] green_lane [num_pixels];
  logic [PIXEL_W-1:0] blue_lane  [num_pixels];
  logic [PIXEL_W-1:0] cur_r, cur_g, cur_b;
  logic               cur_match;
  logic               take_operands;

  // Unpack the latched buses into lane arrays so the active lane is a mux.
  for (genvar gi = 0; gi < num_pixels; gi++) begin : g_unpack
    assign red_lane[gi]   = red_reg[gi*PIXEL_W +: PIXEL_W];
    assign green_lane[gi] = green_reg[gi*PIXEL_W +: PIXEL_W];
    assign blue_lane[gi]  = blue_reg[gi*PIXEL_W +: PIXEL_W];
  end

  assign cur_r = red_lane[idx_reg];
  assign cur_g = green_lane[idx_reg];
  assign cur_b = blue_lane[idx_reg];

  bg_pixel_compare u_cmp (
    .r         (cur_r),
    .g         (cur_g),
    .b         (cur_b),
    .exp_r     (exp_r_reg),
    .exp_g     (exp_g_reg),
    .exp_b     (exp_b_reg),
    .threshold (thr_reg),
    .match     (cur_match)
  );

  assign take_operands = (state_reg == ST_I) && (Start_Sum || Start_BgRemoval);

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_I:    if (Start_Sum)            state_next = ST_SI;
               else if (Start_BgRemoval) state_next = ST_BGI;
      ST_SI:   state_next = ST_S;
      ST_BGI:  state_next = ST_BG;
      ST_S:    if (idx_reg == LAST_IDX)  state_next = ST_SD;
      ST_BG:   if (idx_reg == LAST_IDX)  state_next = ST_BGD;
      ST_SD:   if (Ack)                  state_next = ST_I;
      ST_BGD:  if (Ack)                  state_next = ST_I;
      default: state_next = ST_I;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= ST_I;
      idx_reg   <= '0;
      red_reg   <= '0;
      green_reg <= '0;
      blue_reg  <= '0;
      exp_r_reg <= '0;
      exp_g_reg <= '0;
      exp_b_reg <= '0;
      thr_reg   <= '0;
      des_r_reg <= '0;
      des_g_reg <= '0;
      des_b_reg <= '0;
      sum_r_reg <= '0;
      sum_g_reg <= '0;
      sum_b_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (take_operands) begin
        red_reg   <= red_in;
        green_reg <= green_in;
        blue_reg  <= blue_in;
        exp_r_reg <= red_exp;
        exp_g_reg <= green_exp;
        exp_b_reg <= blue_exp;
        thr_reg   <= threshold;
        des_r_reg <= desired_bg_r;
        des_g_reg <= desired_bg_g;
        des_b_reg <= desired_bg_b;
      end
      if (state_reg == ST_SI) begin
        sum_r_reg <= '0;
        sum_g_reg <= '0;
        sum_b_reg <= '0;
      end else if (state_reg == ST_S) begin
        sum_r_reg <= sum_r_reg + BUS_W'(cur_r);
        sum_g_reg <= sum_g_reg + BUS_W'(cur_g);
        sum_b_reg <= sum_b_reg + BUS_W'(cur_b);
      end
      if (state_reg == ST_SI || state_reg == ST_BGI) begin
        idx_reg <= '0;
      end else if (state_reg == ST_S || state_reg == ST_BG) begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  // Each output lane owns its register and updates only when it is the active BG lane.
  for (genvar gi = 0; gi < num_pixels; gi++) begin : g_out
    logic [PIXEL_W-1:0] out_r_reg, out_g_reg, out_b_reg;

    always_ff @(posedge Clk) begin
      if (Reset) begin
        out_r_reg <= '0;
        out_g_reg <= '0;
        out_b_reg <= '0;
      end else if (state_reg == ST_BG && idx_reg == IDX_W'(gi)) begin
        out_r_reg <= cur_match ? des_r_reg : cur_r;
        out_g_reg <= cur_match ? des_g_reg : cur_g;
        out_b_reg <= cur_match ? des_b_reg : cur_b;
      end
    end

    assign red_out[gi*PIXEL_W +: PIXEL_W]   = out_r_reg;
    assign green_out[gi*PIXEL_W +: PIXEL_W] = out_g_reg;
    assign blue_out[gi*PIXEL_W +: PIXEL_W]  = out_b_reg;
  end

  assign red_sum   = sum_r_reg;
  assign green_sum = sum_g_reg;
  assign blue_sum  = sum_b_reg;

  assign Qi   = (state_reg == ST_I);
  assign Qbgi = (state_reg == ST_BGI);
  assign Qbg  = (state_reg == ST_BG);
  assign Qbgd = (state_reg == ST_BGD);
  assign Qsi  = (state_reg == ST_SI);
  assign Qs   = (state_reg == ST_S);
  assign Qsd  = (state_reg == ST_SD);

endmodule

// File: tb/tb_pe.sv
// Self-checking bench for pe: directed steps on a 1-lane instance and
// randomized runs on a 4-lane instance against an arithmetic reference model.
module tb_pe;

  localparam logic [6:0] F_I   = 7'b1000000;
  localparam logic [6:0] F_BGI = 7'b0100000;
  localparam logic [6:0] F_BG  = 7'b0010000;
  localparam logic [6:0] F_BGD = 7'b0001000;
  localparam logic [6:0] F_SI  = 7'b0000100;
  localparam logic [6:0] F_S   = 7'b0000010;
  localparam logic [6:0] F_SD  = 7'b0000001;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [7:0] er, eg, eb, thr, dr, dg, db;

  logic       reset1, ack1, ss1, sb1;
  logic [7:0] ri1, gi1, bi1;
  logic [7:0] ro1, go1, bo1, rs1, gs1, bs1;
  logic       qi1, qbgi1, qbg1, qbgd1, qsi1, qs1, qsd1;

  logic        reset4, ack4, ss4, sb4;
  logic [31:0] ri4, gi4, bi4;
  logic [31:0] ro4, go4, bo4, rs4, gs4, bs4;
  logic        qi4, qbgi4, qbg4, qbgd4, qsi4, qs4, qsd4;

  logic [6:0] flags1, flags4;
  assign flags1 = {qi1, qbgi1, qbg1, qbgd1, qsi1, qs1, qsd1};
  assign flags4 = {qi4, qbgi4, qbg4, qbgd4, qsi4, qs4, qsd4};

  pe #(.num_pixels(1)) dut1 (
    .Clk(Clk), .Ack(ack1), .Reset(reset1),
    .red_exp(er), .green_exp(eg), .blue_exp(eb), .threshold(thr),
    .desired_bg_r(dr), .desired_bg_g(dg), .desired_bg_b(db),
    .Start_Sum(ss1), .Start_BgRemoval(sb1),
    .red_in(ri1), .green_in(gi1), .blue_in(bi1),
    .red_out(ro1), .green_out(go1), .blue_out(bo1),
    .Qi(qi1), .Qbgi(qbgi1), .Qbg(qbg1), .Qbgd(qbgd1), .Qsi(qsi1), .Qs(qs1), .Qsd(qsd1),
    .red_sum(rs1), .green_sum(gs1), .blue_sum(bs1)
  );

  pe #(.num_pixels(4)) dut4 (
    .Clk(Clk), .Ack(ack4), .Reset(reset4),
    .red_exp(er), .green_exp(eg), .blue_exp(eb), .threshold(thr),
    .desired_bg_r(dr), .desired_bg_g(dg), .desired_bg_b(db),
    .Start_Sum(ss4), .Start_BgRemoval(sb4),
    .red_in(ri4), .green_in(gi4), .blue_in(bi4),
    .red_out(ro4), .green_out(go4), .blue_out(bo4),
    .Qi(qi4), .Qbgi(qbgi4), .Qbg(qbg4), .Qbgd(qbgd4), .Qsi(qsi4), .Qs(qs4), .Qsd(qsd4),
    .red_sum(rs4), .green_sum(gs4), .blue_sum(bs4)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state for the 4-lane instance.
  int lr[4], lg[4], lb[4];
  logic [31:0] m_rs, m_gs, m_bs, m_ro, m_go, m_bo;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      $error("check %s differs", tag);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Model: compute expected sums or replaced lanes straight from the rules.
  task automatic model4(input bit is_sum);
    int s_r, s_g, s_b;
    bit hit;
    s_r = 0; s_g = 0; s_b = 0;
    for (int k = 0; k < 4; k++) begin
      if (is_sum) begin
        s_r += lr[k]; s_g += lg[k]; s_b += lb[k];
      end else begin
        hit = (iabs(lr[k] - int'(er)) <= int'(thr)) &&
              (iabs(lg[k] - int'(eg)) <= int'(thr)) &&
              (iabs(lb[k] - int'(eb)) <= int'(thr));
        m_ro[8*k +: 8] = hit ? dr : 8'(lr[k]);
        m_go[8*k +: 8] = hit ? dg : 8'(lg[k]);
        m_bo[8*k +: 8] = hit ? db : 8'(lb[k]);
      end
    end
    if (is_sum) begin
      m_rs = 32'(s_r); m_gs = 32'(s_g); m_bs = 32'(s_b);
    end
  endtask

  task automatic run4(input string tag, input bit is_sum);
    int cnt;
    for (int k = 0; k < 4; k++) begin
      ri4[8*k +: 8] = 8'(lr[k]);
      gi4[8*k +: 8] = 8'(lg[k]);
      bi4[8*k +: 8] = 8'(lb[k]);
    end
    model4(is_sum);
    ack4 = 1'b0;
    if (is_sum) ss4 = 1'b1; else sb4 = 1'b1;
    tick();
    ss4 = 1'b0; sb4 = 1'b0;
    chk({tag, "_init"}, 32'(flags4), 32'(is_sum ? F_SI : F_BGI));
    ri4 = $urandom; gi4 = $urandom; bi4 = $urandom;
    cnt = 0;
    while (!(qsd4 || qbgd4) && cnt < 20) begin
      tick();
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'd5);
    chk({tag, "_done"}, 32'(flags4), 32'(is_sum ? F_SD : F_BGD));
    chk({tag, "_rsum"}, rs4, m_rs);
    chk({tag, "_gsum"}, gs4, m_gs);
    chk({tag, "_bsum"}, bs4, m_bs);
    chk({tag, "_rout"}, ro4, m_ro);
    chk({tag, "_gout"}, go4, m_go);
    chk({tag, "_bout"}, bo4, m_bo);
    ack4 = 1'b1;
    tick();
    ack4 = 1'b0;
    chk({tag, "_back"}, 32'(flags4), 32'(F_I));
    $display("run %s %s: sums=%0d/%0d/%0d out=%h/%h/%h", tag, is_sum ? "sum" : "bg",
             rs4, gs4, bs4, ro4, go4, bo4);
  endtask

  task automatic bg1(input string tag, input logic [7:0] r, input logic [7:0] g,
                     input logic [7:0] b, input logic [23:0] exp_v);
    ri1 = r; gi1 = g; bi1 = b;
    ack1 = 1'b1;
    sb1 = 1'b1;
    tick();
    sb1 = 1'b0;
    tick();
    tick();
    chk({tag, "_state"}, 32'(flags1), 32'(F_BGD));
    chk({tag, "_out"}, 32'({ro1, go1, bo1}), 32'(exp_v));
    tick();
    $display("bg1 %s: in=(%0d,%0d,%0d) out=(%0d,%0d,%0d)", tag, r, g, b, ro1, go1, bo1);
  endtask

  initial begin
    logic [23:0] held;
    er = 0; eg = 0; eb = 0; thr = 0; dr = 0; dg = 0; db = 0;
    ack1 = 0; ss1 = 0; sb1 = 0; ri1 = 0; gi1 = 0; bi1 = 0;
    ack4 = 0; ss4 = 0; sb4 = 0; ri4 = 0; gi4 = 0; bi4 = 0;
    m_rs = 0; m_gs = 0; m_bs = 0; m_ro = 0; m_go = 0; m_bo = 0;

    // Reset: start requests during reset must be overridden.
    reset1 = 1; reset4 = 1; ss1 = 1; ss4 = 1;
    repeat (5) tick();
    ss1 = 0; ss4 = 0;
    chk("rst1_flags", 32'(flags1), 32'(F_I));
    chk("rst1_outs", 32'({ro1, go1, bo1, rs1}), 32'd0);
    chk("rst1_sums", 32'({gs1, bs1}), 32'd0);
    chk("rst4_flags", 32'(flags4), 32'(F_I));
    chk("rst4_sums", rs4 | gs4 | bs4, 32'd0);
    chk("rst4_outs", ro4 | go4 | bo4, 32'd0);
    reset1 = 0; reset4 = 0;
    tick();

    // N=1 summation walk-through.
    ri1 = 61; gi1 = 133; bi1 = 198; ack1 = 1;
    ss1 = 1;
    tick();
    ss1 = 0; ri1 = 7; gi1 = 7; bi1 = 7;
    chk("sum1_si", 32'(flags1), 32'(F_SI));
    tick();
    chk("sum1_s", 32'(flags1), 32'(F_S));
    tick();
    chk("sum1_sd", 32'(flags1), 32'(F_SD));
    chk("sum1_vals", 32'({rs1, gs1, bs1}), {8'd0, 8'd61, 8'd133, 8'd198});
    tick();
    chk("sum1_i", 32'(flags1), 32'(F_I));
    chk("sum1_hold", 32'({rs1, gs1, bs1}), {8'd0, 8'd61, 8'd133, 8'd198});
    $display("sum1: sums=(%0d,%0d,%0d)", rs1, gs1, bs1);

    // N=1 background removal and the inclusive threshold boundary.
    er = 61; eg = 133; eb = 198; thr = 30; dr = 10; dg = 10; db = 10;
    bg1("bg1_match", 8'd61, 8'd133, 8'd198, {8'd10, 8'd10, 8'd10});
    bg1("bg1_edge", 8'd61, 8'd133, 8'd228, {8'd10, 8'd10, 8'd10});
    bg1("bg1_over", 8'd61, 8'd133, 8'd229, {8'd61, 8'd133, 8'd229});
    chk("bg1_sum_held", 32'({rs1, gs1, bs1}), {8'd0, 8'd61, 8'd133, 8'd198});

    // Done state holds while Ack is low.
    ri1 = 1; gi1 = 2; bi1 = 3; ack1 = 0;
    sb1 = 1;
    tick();
    sb1 = 0;
    tick();
    tick();
    held = {ro1, go1, bo1};
    chk("ack_out", 32'(held), {8'd0, 8'd1, 8'd2, 8'd3});
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ack_wait_state", 32'(flags1), 32'(F_BGD));
      chk("ack_wait_out", 32'({ro1, go1, bo1}), 32'(held));
    end
    ack1 = 1;
    tick();
    chk("ack_release", 32'(flags1), 32'(F_I));

    // Both starts together: summation wins; starts in S are ignored.
    ri1 = 200; gi1 = 100; bi1 = 50;
    ss1 = 1; sb1 = 1;
    tick();
    ss1 = 0; sb1 = 0;
    chk("prio_si", 32'(flags1), 32'(F_SI));
    tick();
    chk("prio_s", 32'(flags1), 32'(F_S));
    ss1 = 1; sb1 = 1;
    tick();
    ss1 = 0; sb1 = 0;
    chk("ignore_sd", 32'(flags1), 32'(F_SD));
    chk("ignore_sum", 32'({rs1, gs1, bs1}), {8'd0, 8'd200, 8'd100, 8'd50});
    tick();
    chk("ignore_i", 32'(flags1), 32'(F_I));

    // N=4 all-255 summation.
    for (int k = 0; k < 4; k++) begin
      lr[k] = 255; lg[k] = 255; lb[k] = 255;
    end
    run4("full", 1'b1);
    chk("full_1020", rs4, 32'd1020);

    // N=4 randomized runs against the model.
    for (int it = 0; it < 12; it++) begin
      bit do_sum;
      do_sum = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        lr[k] = $urandom_range(0, 255);
        lg[k] = $urandom_range(0, 255);
        lb[k] = $urandom_range(0, 255);
      end
      er = 8'(lr[$urandom_range(0, 3)]);
      eg = 8'(lg[$urandom_range(0, 3)]);
      eb = 8'(lb[$urandom_range(0, 3)]);
      thr = 8'($urandom_range(0, 255));
      dr = 8'($urandom); dg = 8'($urandom); db = 8'($urandom);
      run4($sformatf("rnd%0d", it), do_sum);
    end

    // Reset during S aborts the run and clears everything.
    for (int k = 0; k < 4; k++) begin
      lr[k] = k + 1; lg[k] = k + 2; lb[k] = k + 3;
      ri4[8*k +: 8] = 8'(lr[k]); gi4[8*k +: 8] = 8'(lg[k]); bi4[8*k +: 8] = 8'(lb[k]);
    end
    ss4 = 1;
    tick();
    ss4 = 0;
    tick();
    tick();
    chk("abort_in_s", 32'(flags4), 32'(F_S));
    reset4 = 1; ack4 = 1; sb4 = 1;
    tick();
    reset4 = 0; ack4 = 0; sb4 = 0;
    chk("abort_flags", 32'(flags4), 32'(F_I));
    chk("abort_sums", rs4 | gs4 | bs4, 32'd0);
    chk("abort_outs", ro4 | go4 | bo4, 32'd0);
    $display("abort: flags=%b sums=%0d/%0d/%0d", flags4, rs4, gs4, bs4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
